// File: rtl/jpeg_bit_packer_if.sv
// rtl/jpeg_bit_packer_if.sv - code-field input and byte-stream output bundle of the JPEG bit packer
interface jpeg_bit_packer_if;
  logic [5:0]  ilength;
  logic [31:0] idata;
  logic [31:0] idata_nostuff;
  logic [2:0]  rest;
  logic        jvalid;
  logic [7:0]  jpeg;
  logic        overflow;

  modport master (
    output ilength, idata, idata_nostuff,
    input  rest, jvalid, jpeg, overflow
  );

  modport slave (
    input  ilength, idata, idata_nostuff,
    output rest, jvalid, jpeg, overflow
  );
endinterface

// File: rtl/jpeg_bit_packer.sv
// rtl/jpeg_bit_packer.sv - packs VLC fields MSB-first into 32-bit words, buffers them, emits stuffed bytes
module jpeg_bit_packer #(
  parameter int FIFO_AW = 9
) (
  input logic              clk,
  input logic              rst,
  jpeg_bit_packer_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [4:0]  cnt;
  logic [31:0] acc_d, acc_m;
  logic [5:0]  len, sum;
  logic [4:0]  keep;
  logic [63:0] fmask, kmask, cat_d, cat_m;
  logic        word_done;
  logic [31:0] word_d, word_m;

  // Both accumulators hold only their low cnt bits; everything above is kept zero.
  always_comb begin
    len       = (bus.ilength > 6'd32) ? 6'd32 : bus.ilength;
    fmask     = ~(~64'd0 << len);
    cat_d     = ({32'd0, acc_d} << len) | ({32'd0, bus.idata} & fmask);
    cat_m     = ({32'd0, acc_m} << len) | ({32'd0, bus.idata_nostuff} & fmask);
    sum       = {1'b0, cnt} + len;
    word_done = (sum >= 6'd32);
    keep      = word_done ? 5'(sum - 6'd32) : sum[4:0];
    kmask     = ~(~64'd0 << keep);
    word_d    = 32'(cat_d >> (sum - 6'd32));
    word_m    = 32'(cat_m >> (sum - 6'd32));
  end

  logic        stg_valid;
  logic [31:0] stg_word;
  logic [3:0]  stg_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc_d     <= '0;
      acc_m     <= '0;
      stg_valid <= 1'b0;
      stg_word  <= '0;
      stg_flags <= '0;
    end else begin
      cnt       <= keep;
      acc_d     <= 32'(cat_d & kmask);
      acc_m     <= 32'(cat_m & kmask);
      stg_valid <= word_done;
      if (word_done) begin
        stg_word  <= word_d;
        stg_flags <= {word_m[31:24] == 8'hFF, word_m[23:16] == 8'hFF,
                      word_m[15:8] == 8'hFF, word_m[7:0] == 8'hFF};
      end
    end
  end

  logic [35:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, wr_en, pop;
  logic [35:0]      rd_data;

  logic [31:0] sh_word;
  logic [3:0]  sh_flags;
  logic [2:0]  sh_cnt;
  logic        stuff_pend;
  logic        jvalid_q;
  logic [7:0]  jpeg_q;
  logic        overflow_q;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign rd_data    = mem[rd_ptr[FIFO_AW-1:0]];
  // Reload while the last byte goes out so consecutive words leave no gap.
  assign pop        = !fifo_empty && ((sh_cnt == 3'd0) || (sh_cnt == 3'd1 && !stuff_pend));
  assign wr_en      = stg_valid && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= {stg_word, stg_flags};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      sh_word    <= '0;
      sh_flags   <= '0;
      sh_cnt     <= '0;
      stuff_pend <= 1'b0;
      jvalid_q   <= 1'b0;
      jpeg_q     <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (stg_valid && fifo_full && !pop) overflow_q <= 1'b1;
      jvalid_q <= 1'b0;
      if (stuff_pend) begin
        jpeg_q     <= 8'h00;
        jvalid_q   <= 1'b1;
        stuff_pend <= 1'b0;
      end else if (sh_cnt != 3'd0) begin
        jpeg_q     <= sh_word[31:24];
        jvalid_q   <= 1'b1;
        stuff_pend <= (sh_word[31:24] == 8'hFF) && !sh_flags[3];
        sh_word    <= {sh_word[23:0], 8'h00};
        sh_flags   <= {sh_flags[2:0], 1'b0};
        sh_cnt     <= sh_cnt - 3'd1;
      end
      if (pop) begin
        sh_word  <= rd_data[35:4];
        sh_flags <= rd_data[3:0];
        sh_cnt   <= 3'd4;
      end
    end
  end

  assign bus.rest     = 3'd0 - cnt[2:0];
  assign bus.jvalid   = jvalid_q;
  assign bus.jpeg     = jpeg_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb/tb_jpeg_bit_packer.sv - bench for jpeg_bit_packer against a bit-queue stream model
module tb_jpeg_bit_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jpeg_bit_packer_if bus();
  jpeg_bit_packer #(.FIFO_AW(9)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit           mbits_d[$];
  bit           mbits_m[$];
  byte unsigned exp_q[$];
  bit           model_on = 1'b1;
  int           seen_cyc[$];
  byte unsigned seen_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream model: the accepted bits form one long sequence; every 32 bits make a word.
  function automatic void model_accept(input int len, input logic [31:0] d, input logic [31:0] m);
    int l;
    byte unsigned v, mv;
    l = (len > 32) ? 32 : len;
    for (int i = l - 1; i >= 0; i--) begin
      mbits_d.push_back(d[i]);
      mbits_m.push_back(m[i]);
    end
    while (mbits_d.size() >= 32) begin
      for (int b = 0; b < 4; b++) begin
        v = 0;
        mv = 0;
        for (int k = 0; k < 8; k++) begin
          v  = {v[6:0], mbits_d.pop_front()};
          mv = {mv[6:0], mbits_m.pop_front()};
        end
        exp_q.push_back(v);
        if (v == 8'hFF && mv != 8'hFF) exp_q.push_back(8'h00);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      chk("rest", bus.rest, (8 - mbits_d.size() % 8) % 8);
      chk("overflow_clear", bus.overflow, 0);
    end
    if (bus.jvalid === 1'b1) begin
      seen_cyc.push_back(cyc);
      seen_b.push_back(bus.jpeg);
      if (model_on) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected no strobe (t=%0t)", bus.jpeg, $time);
        end else begin
          chk("jpeg", bus.jpeg, exp_q.pop_front());
        end
      end
    end
    if (rst) begin
      mbits_d.delete();
      mbits_m.delete();
      exp_q.delete();
    end else if (model_on && bus.ilength != 6'd0) begin
      model_accept(int'(bus.ilength), bus.idata, bus.idata_nostuff);
    end
  end

  task automatic send(input int len, input logic [31:0] d, input logic [31:0] m);
    bus.ilength       = 6'(len);
    bus.idata         = d;
    bus.idata_nostuff = m;
    @(posedge clk); #1;
    bus.ilength = 6'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_seen(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (seen_b.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    idle(4);
    chk(name, seen_b.size(), n);
  endtask

  task automatic check_bytes(input string name, input byte unsigned ref_b[$], input int first_cyc);
    if (seen_b.size() == ref_b.size()) begin
      for (int i = 0; i < ref_b.size(); i++) begin
        chk(name, seen_b[i], ref_b[i]);
        chk({name, "_cycle"}, seen_cyc[i], first_cyc + i);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int len;
    logic [31:0] d, m;
    bit seen_ovf;
    byte unsigned r2[$], r3[$], r4[$], r5[$];
    r2 = '{8'h12, 8'h34, 8'h56, 8'h78};
    r3 = '{8'hBF, 8'h00, 8'h00, 8'h00};
    r4 = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hAB};
    r5 = '{8'hFF, 8'h00, 8'hFF, 8'hAB};

    rst = 1'b1;
    bus.ilength = 6'd0;
    bus.idata = '0;
    bus.idata_nostuff = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      chk("t1_rest", bus.rest, 0);
      chk("t1_jvalid", bus.jvalid, 0);
      chk("t1_overflow", bus.overflow, 0);
      @(posedge clk); #1;
    end

    seen_b.delete(); seen_cyc.delete();
    send(8, 32'h12, 0); send(8, 32'h34, 0); send(8, 32'h56, 0); send(8, 32'h78, 0);
    e = cyc;
    wait_seen("t2_count", 4, 20);
    check_bytes("t2_byte", r2, e + 3);

    seen_b.delete(); seen_cyc.delete();
    send(3, 32'b101, 0);
    chk("t3_rest5", bus.rest, 5);
    send(5, 32'h1F, 0);
    chk("t3_rest0", bus.rest, 0);
    send(24, 32'h0, 0);
    e = cyc;
    wait_seen("t3_count", 4, 20);
    check_bytes("t3_byte", r3, e + 3);

    seen_b.delete(); seen_cyc.delete();
    send(32, 32'hFF00FFAB, 32'h0);
    e = cyc;
    wait_seen("t4_count", 6, 20);
    check_bytes("t4_byte", r4, e + 3);

    seen_b.delete(); seen_cyc.delete();
    send(32, 32'hFF00FFAB, 32'hFFFFFFFF);
    e = cyc;
    wait_seen("t5_count", 4, 20);
    check_bytes("t5_byte", r5, e + 3);

    for (int i = 0; i < 300; i++) begin
      len = $urandom_range(0, 63);
      for (int b = 0; b < 4; b++) begin
        d[b*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        m[b*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 1) ? 8'h00 : 8'($urandom));
      end
      send(len, d, m);
      idle($urandom_range(4, 10));
    end
    e = 0;
    while (exp_q.size() != 0 && e < 3000) begin
      @(posedge clk); #1;
      e++;
    end
    idle(10);
    chk("random_drained", exp_q.size(), 0);

    model_on = 1'b0;
    seen_ovf = 1'b0;
    bus.ilength = 6'd32;
    bus.idata = 32'hFFFFFFFF;
    bus.idata_nostuff = 32'h0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #1;
      if (seen_ovf) chk("t6_overflow_sticky", bus.overflow, 1);
      else if (bus.overflow === 1'b1) seen_ovf = 1'b1;
    end
    chk("t6_overflow_set", bus.overflow, 1);
    bus.ilength = 6'd0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_overflow_after_rst", bus.overflow, 0);
    chk("t6_jvalid_after_rst", bus.jvalid, 0);
    model_on = 1'b1;
    seen_b.delete(); seen_cyc.delete();
    idle(20);
    chk("t6_no_leftover", seen_b.size(), 0);

    send(32, 32'h12345678, 32'h0);
    e = cyc;
    wait_seen("t6_post_count", 4, 20);
    check_bytes("t6_post_byte", r2, e + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
